// File: rtl/sysarr_pkg.sv
// Shared constants and state encoding for the 4x4 systolic-array sequencer.
package sysarr_pkg;

  localparam int N         = 4;               // array dimension (edge count is fixed)
  localparam int DW        = 32;              // operand width per element
  localparam int FEED_CYC  = 2 * N - 1;       // skewed feed steps t = 0..2N-2
  localparam int DRAIN_CYC = N - 1;           // zero-feed cycles for the last operand to cross the array
  localparam int LAST_CYC  = FEED_CYC + DRAIN_CYC - 1;  // final step count value before returning idle

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sysarr_skew.sv
// Combinational skew selector: picks one operand per edge lane for step t.
// col_sel=0 walks rows (lane k gets M[k][t-k]); col_sel=1 walks columns (lane k gets M[t-k][k]).
import sysarr_pkg::*;

module sysarr_skew (
  input  logic [N*N*DW-1:0] ops,
  input  logic              col_sel,
  input  logic [3:0]        t,
  output logic [N*DW-1:0]   feed
);

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [3:0]    off_s;
    logic [3:0]    idx_s;
    logic [DW-1:0] lane_s;

    // Select the element entering this lane at step t, zero outside the skew window
    always_comb begin
      off_s = t - 4'(k);
      if (col_sel) begin
        idx_s = {off_s[1:0], 2'(k)};
      end else begin
        idx_s = {2'(k), off_s[1:0]};
      end
      if ((t >= 4'(k)) && (off_s <= 4'd3)) begin
        lane_s = ops[DW*idx_s +: DW];
      end else begin
        lane_s = {DW{1'b0}};
      end
    end

    assign feed[DW*k +: DW] = lane_s;
  end

endmodule

// File: rtl/sysarr_seq.sv
// Sequencer for the 4x4 output-stationary systolic array: buffers A/B from the host,
// clears the array, streams skewed operands onto its edges, waits for drain, flags done.
import sysarr_pkg::*;

module sysarr_seq (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_b,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            arr_clr,
  output logic [4*DW-1:0] a_feed,
  output logic [4*DW-1:0] b_feed,
  output logic [3:0]      cyc
);

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                done_r, done_s;
  logic                busy_r, arr_clr_r;
  logic [4*DW-1:0]     a_feed_r, b_feed_r;
  logic [N*N*DW-1:0]   a_buf_r, b_buf_r;
  logic [N*DW-1:0]     a_sel_s, b_sel_s;

  // Feeds are selected for the step the counter is about to enter so they can be registered
  sysarr_skew u_skew_a (.ops(a_buf_r), .col_sel(1'b0), .t(cnt_s), .feed(a_sel_s));
  sysarr_skew u_skew_b (.ops(b_buf_r), .col_sel(1'b1), .t(cnt_s), .feed(b_sel_s));

  // Operand buffers: host writes land only while idle, so a run sees frozen operands
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == IDLE)) begin
      if (wr_b) begin
        b_buf_r[DW*wr_addr +: DW] <= wr_data;
      end else begin
        a_buf_r[DW*wr_addr +: DW] <= wr_data;
      end
    end
  end

  // Next state, step counter and done flag
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = done_r;
    case (state_r)
      IDLE: begin
        cnt_s = 4'd0;
        if (start) begin
          state_s = CLEAR;
          done_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        state_s = FEED;
        cnt_s   = 4'd0;
      end
      FEED: begin
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == 4'(FEED_CYC - 1)) begin
          state_s = DRAIN;
        end else begin
          state_s = FEED;
        end
      end
      DRAIN: begin
        if (cnt_r == 4'(LAST_CYC)) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
          cnt_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      arr_clr_r <= 1'b0;
      a_feed_r  <= {(4*DW){1'b0}};
      b_feed_r  <= {(4*DW){1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      done_r    <= done_s;
      busy_r    <= (state_s != IDLE);
      arr_clr_r <= (state_s == CLEAR);
      a_feed_r  <= (state_s == FEED) ? a_sel_s : {(4*DW){1'b0}};
      b_feed_r  <= (state_s == FEED) ? b_sel_s : {(4*DW){1'b0}};
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign arr_clr = arr_clr_r;
  assign a_feed  = a_feed_r;
  assign b_feed  = b_feed_r;
  assign cyc     = cnt_r;

endmodule

// File: tb/tb_sysarr_seq.sv
// Self-checking bench for sysarr_seq: per-cycle control table, feed-rule model and a
// behavioural systolic-product check (captured feeds must reproduce A*B).
module tb_sysarr_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, wr_b, start;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         busy, done, arr_clr;
  logic [127:0] a_feed, b_feed;
  logic [3:0]   cyc;

  sysarr_seq dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_b(wr_b), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .arr_clr(arr_clr), .a_feed(a_feed), .b_feed(b_feed), .cyc(cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       done;
    logic       clr;
    logic [3:0] cyc;
  } vec_t;

  vec_t         tbl [1:12];
  logic [31:0]  ma [4][4];
  logic [31:0]  mb [4][4];
  logic [127:0] ah [10];
  logic [127:0] bh [10];
  logic [127:0] ah0 [10];
  logic [127:0] bh0 [10];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected edge feed at step t straight from the skew rule
  function automatic logic [127:0] model_feed(input bit is_b, input int t);
    logic [127:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      if (t - k >= 0 && t - k <= 3) r[32*k +: 32] = is_b ? mb[t-k][k] : ma[k][t-k];
    end
    return r;
  endfunction

  task automatic wr(input bit b, input int r, input int c, input logic [31:0] d);
    wr_en = 1'b1; wr_b = b; wr_addr = 4'(r * 4 + c); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (b) mb[r][c] = d; else ma[r][c] = d;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk(nm, {127'd0, busy}, 128'd0);
  endtask

  // One full run from IDLE: optional write alongside start, optional write at table step mid_k
  task automatic run_check(input string tag, input bit ws, input bit ws_b, input int ws_r,
                           input int ws_c, input logic [31:0] ws_d, input int mid_k,
                           input logic [3:0] mid_addr, input logic [31:0] mid_d);
    logic [31:0] acc, ref_v;
    int s1, s2;
    start = 1'b1;
    if (ws) begin
      wr_en = 1'b1; wr_b = ws_b; wr_addr = 4'(ws_r * 4 + ws_c); wr_data = ws_d;
      if (ws_b) mb[ws_r][ws_c] = ws_d; else ma[ws_r][ws_c] = ws_d;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("%s busy k%0d", tag, k), {127'd0, busy}, {127'd0, tbl[k].busy});
      chk($sformatf("%s done k%0d", tag, k), {127'd0, done}, {127'd0, tbl[k].done});
      chk($sformatf("%s clr k%0d", tag, k), {127'd0, arr_clr}, {127'd0, tbl[k].clr});
      chk($sformatf("%s cyc k%0d", tag, k), {124'd0, cyc}, {124'd0, tbl[k].cyc});
      if (k >= 2 && k <= 8) begin
        chk($sformatf("%s a_feed t%0d", tag, k - 2), a_feed, model_feed(1'b0, k - 2));
        chk($sformatf("%s b_feed t%0d", tag, k - 2), b_feed, model_feed(1'b1, k - 2));
      end else begin
        chk($sformatf("%s a_zero k%0d", tag, k), a_feed, 128'd0);
        chk($sformatf("%s b_zero k%0d", tag, k), b_feed, 128'd0);
      end
      if (k >= 2 && k <= 11) begin
        ah[k-2] = a_feed;
        bh[k-2] = b_feed;
      end
      if (k == mid_k) begin
        wr_en = 1'b1; wr_b = 1'b0; wr_addr = mid_addr; wr_data = mid_d;
      end
      if (k < 12) begin
        tick();
        wr_en = 1'b0;
      end
    end
    // PE(i,j) at time t meets row i from step t-j and column j from step t-i
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 32'd0; ref_v = 32'd0;
        for (int t = 0; t < 16; t++) begin
          s1 = t - j; s2 = t - i;
          if (s1 >= 0 && s1 < 10 && s2 >= 0 && s2 < 10)
            acc = acc + ah[s1][32*i +: 32] * bh[s2][32*j +: 32];
        end
        for (int k = 0; k < 4; k++) ref_v = ref_v + ma[i][k] * mb[k][j];
        chk($sformatf("%s prod r%0d%0d", tag, i + 1, j + 1), {96'd0, acc}, {96'd0, ref_v});
      end
    end
  endtask

  initial begin
    int n;
    for (int k = 1; k <= 12; k++) begin
      tbl[k].busy = (k <= 11);
      tbl[k].done = (k == 12);
      tbl[k].clr  = (k == 1);
      tbl[k].cyc  = (k >= 2 && k <= 11) ? 4'(k - 2) : 4'd0;
    end
    rst = 1'b1; wr_en = 1'b0; wr_b = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; start = 1'b0;
    #12;
    chk("reset ctl", {124'd0, busy, done, arr_clr, 1'b0}, 128'd0);
    chk("reset cyc", {124'd0, cyc}, 128'd0);
    chk("reset feeds", a_feed | b_feed, 128'd0);
    rst = 1'b0;
    tick();

    // A = identity, B[i][j] = 4i+j+1
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(1'b0, i, j, (i == j) ? 32'd1 : 32'd0);
        wr(1'b1, i, j, 32'(4 * i + j + 1));
      end
    chk("no done before run", {127'd0, done}, 128'd0);
    run_check("ident", 1'b0, 1'b0, 0, 0, 32'd0, -1, 4'd0, 32'd0);
    chk("ident t0 a", ah[0], {32'd0, 32'd0, 32'd0, 32'd1});
    chk("ident t0 b", bh[0], {32'd0, 32'd0, 32'd0, 32'd1});
    chk("ident t3 b", bh[3], {32'd4, 32'd7, 32'd10, 32'd13});
    chk("ident t6 a", ah[6], {32'd1, 32'd0, 32'd0, 32'd0});
    chk("ident t6 b", bh[6], {32'd16, 32'd0, 32'd0, 32'd0});

    // Write with start commits; write during the run is ignored
    run_check("wrstart", 1'b1, 1'b0, 0, 0, 32'd5, 4, 4'd12, 32'hDEAD);
    chk("wrstart t0 a0", {96'd0, ah[0][31:0]}, 128'd5);
    chk("midwr t3 a3", {96'd0, ah[3][127:96]}, 128'd0);

    // Back-to-back runs without writes repeat exactly
    run_check("b2b1", 1'b0, 1'b0, 0, 0, 32'd0, -1, 4'd0, 32'd0);
    for (int s = 0; s < 10; s++) begin ah0[s] = ah[s]; bh0[s] = bh[s]; end
    run_check("b2b2", 1'b0, 1'b0, 0, 0, 32'd0, -1, 4'd0, 32'd0);
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("b2b a s%0d", s), ah[s], ah0[s]);
      chk($sformatf("b2b b s%0d", s), bh[s], bh0[s]);
    end

    // Start held high: second run only from the first idle cycle
    start = 1'b1;
    for (n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("held clr n%0d", n), {127'd0, arr_clr}, {127'd0, (n == 1 || n == 13)});
      if (n == 12) chk("held done S12", {126'd0, done, busy}, 128'd2);
      if (n == 13) chk("held done S13", {127'd0, done}, 128'd0);
    end
    start = 1'b0;
    wait_idle("held idle");

    // Asynchronous reset at t=3
    start = 1'b1; tick(); start = 1'b0;
    for (n = 0; n < 4; n++) tick();
    chk("pre-rst cyc", {124'd0, cyc}, 128'd3);
    #2 rst = 1'b1;
    #1;
    chk("async rst ctl", {124'd0, busy, done, arr_clr, 1'b0}, 128'd0);
    chk("async rst cyc", {124'd0, cyc}, 128'd0);
    chk("async rst feeds", a_feed | b_feed, 128'd0);
    #1 rst = 1'b0;
    tick();
    chk("post-rst idle", {127'd0, busy}, 128'd0);
    run_check("afterrst", 1'b0, 1'b0, 0, 0, 32'd0, -1, 4'd0, 32'd0);

    // Random operands
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          wr(1'b0, i, j, $urandom);
          wr(1'b1, i, j, $urandom);
        end
      chk($sformatf("done kept over writes %0d", r), {127'd0, done}, 128'd1);
      run_check($sformatf("rand%0d", r), 1'b0, 1'b0, 0, 0, 32'd0, -1, 4'd0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
